// File: rtl/stq_pkg.sv
// -----------------------------------------------------------------------------
// stq_pkg
// Shared definitions for the low store-queue entry array:
//   BUF_COUNT  - number of entries in the array (power of two)
//   IDX_W      - width of an entry index
//   stq_idx_t  - entry index
//   stq_ptr_t  - lifecycle pointer: index plus one wrap bit
//   stq_sum_t  - one bit wider than a pointer, for occupancy headroom sums
//   stq_mask_t - one bit per entry
//   onehot()   - entry index to single-bit mask
// -----------------------------------------------------------------------------
package stq_pkg;

  localparam int BUF_COUNT = 32;
  localparam int IDX_W     = $clog2(BUF_COUNT);

  typedef logic [IDX_W-1:0]     stq_idx_t;
  typedef logic [IDX_W:0]       stq_ptr_t;
  typedef logic [IDX_W+1:0]     stq_sum_t;
  typedef logic [BUF_COUNT-1:0] stq_mask_t;

  function automatic stq_mask_t onehot(input stq_idx_t idx);
    stq_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/stq_l_alloc_ctl_if.sv
// -----------------------------------------------------------------------------
// stq_l_alloc_ctl_if
// Bundles every non-clock/reset signal of the store-queue allocation
// controller.
//   allocate : stallA, excpt, alloc_req -> alloc_gnt, alloc_id0/1, wrt0/1_en
//   retire   : retire_cnt -> passe_en
//   drain    : drain_valid, drain_id, drain_ready -> free_en
//   status   : used_cnt, full, empty
// master = pipeline / cache side (drives requests), slave = controller.
// -----------------------------------------------------------------------------
interface stq_l_alloc_ctl_if;
  import stq_pkg::*;

  logic      stallA;
  logic      excpt;
  logic [1:0] alloc_req;
  logic      alloc_gnt;
  stq_idx_t  alloc_id0;
  stq_idx_t  alloc_id1;
  stq_mask_t wrt0_en;
  stq_mask_t wrt1_en;
  logic [1:0] retire_cnt;
  stq_mask_t passe_en;
  logic      drain_valid;
  stq_idx_t  drain_id;
  logic      drain_ready;
  stq_mask_t free_en;
  stq_ptr_t  used_cnt;
  logic      full;
  logic      empty;

  modport master (
    output stallA, excpt, alloc_req, retire_cnt, drain_ready,
    input  alloc_gnt, alloc_id0, alloc_id1, wrt0_en, wrt1_en,
           passe_en, drain_valid, drain_id, free_en,
           used_cnt, full, empty
  );

  modport slave (
    input  stallA, excpt, alloc_req, retire_cnt, drain_ready,
    output alloc_gnt, alloc_id0, alloc_id1, wrt0_en, wrt1_en,
           passe_en, drain_valid, drain_id, free_en,
           used_cnt, full, empty
  );

endinterface

// File: rtl/stq_range_mask.sv
// -----------------------------------------------------------------------------
// stq_range_mask
// Produces a BUF_COUNT-wide mask with the bits for entries
// i_start, i_start+1, ..., i_start+i_count-1 set, wrapping from the top
// entry back to entry 0. i_count may be 0 (empty mask) up to BUF_COUNT
// (all bits set).
//   i_start : first entry of the range
//   i_count : number of entries in the range (0..BUF_COUNT)
//   o_mask  : resulting wrapped mask
// -----------------------------------------------------------------------------
module stq_range_mask
  import stq_pkg::*;
(
  input  stq_idx_t  i_start,
  input  stq_ptr_t  i_count,
  output stq_mask_t o_mask
);

  // Bit g belongs to the range when its distance from i_start, taken
  // modulo BUF_COUNT, is below the count.
  for (genvar g = 0; g < BUF_COUNT; g++) begin : g_bit
    localparam stq_idx_t LP_IDX = stq_idx_t'(g);
    stq_idx_t w_ofs;
    assign w_ofs     = LP_IDX - i_start;
    assign o_mask[g] = ({1'b0, w_ofs} < i_count);
  end

endmodule

// File: rtl/stq_l_alloc_ctl.sv
// -----------------------------------------------------------------------------
// stq_l_alloc_ctl
// In-order lifecycle controller for the low store-queue entry array.
// Entries move free -> allocated -> retired (passe) -> drained (free) and are
// tracked by three wrap-bit pointers, alloc_ptr >= passe_ptr >= free_ptr.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stq_l_alloc_ctl_if.slave
//     allocate up to 2 entries/cycle (alloc_gnt, alloc_id0/1, wrt0/1_en)
//     retire up to 2 entries/cycle   (retire_cnt -> passe_en)
//     drain 1 entry/cycle            (drain_valid/drain_ready -> free_en)
//     flush unretired entries        (excpt -> free_en, alloc_ptr rewinds)
//     occupancy                      (used_cnt, full, empty)
// -----------------------------------------------------------------------------
module stq_l_alloc_ctl
  import stq_pkg::*;
(
  input logic              clk,
  input logic              rst,
  stq_l_alloc_ctl_if.slave bus
);

  localparam stq_sum_t LP_CAP = stq_sum_t'(BUF_COUNT);

  stq_ptr_t  r_alloc_ptr;
  stq_ptr_t  r_passe_ptr;
  stq_ptr_t  r_free_ptr;

  stq_ptr_t  w_used;
  stq_sum_t  w_need;
  logic      w_req_ok;
  logic      w_gnt;
  stq_idx_t  w_id0;
  stq_idx_t  w_id1;

  stq_ptr_t  w_retire_cnt;
  stq_ptr_t  w_passe_cnt;
  stq_ptr_t  w_passe_nxt;
  stq_ptr_t  w_flush_cnt;
  stq_mask_t w_passe_mask;
  stq_mask_t w_flush_mask;

  logic      w_drain_vld;
  logic      w_drain_fire;
  stq_idx_t  w_drain_id;

  // ---------------------------------------------------------------------------
  // Allocation: combinational from the registered pointers. Headroom is
  // judged on the registered occupancy, so a same-cycle drain does not make
  // room until the following cycle.
  // ---------------------------------------------------------------------------
  assign w_used   = r_alloc_ptr - r_free_ptr;
  assign w_need   = {1'b0, w_used} + stq_sum_t'(bus.alloc_req);
  assign w_req_ok = (bus.alloc_req == 2'd1) || (bus.alloc_req == 2'd2);
  assign w_gnt    = ~rst & w_req_ok & ~bus.stallA & ~bus.excpt & (w_need <= LP_CAP);

  assign w_id0 = r_alloc_ptr[IDX_W-1:0];
  assign w_id1 = w_id0 + stq_idx_t'(1);

  assign bus.alloc_gnt = w_gnt;
  assign bus.alloc_id0 = w_id0;
  assign bus.alloc_id1 = w_id1;
  assign bus.wrt0_en   = w_gnt ? onehot(w_id0) : '0;
  assign bus.wrt1_en   = (w_gnt && (bus.alloc_req == 2'd2)) ? onehot(w_id1) : '0;

  // ---------------------------------------------------------------------------
  // Retire and flush. The retire is applied before the flush, so the flush
  // range starts at the post-retire passe pointer and retired entries are
  // never flushed.
  // ---------------------------------------------------------------------------
  assign w_retire_cnt = stq_ptr_t'(bus.retire_cnt);
  assign w_passe_cnt  = rst ? '0 : w_retire_cnt;
  assign w_passe_nxt  = r_passe_ptr + w_retire_cnt;
  assign w_flush_cnt  = (bus.excpt && !rst) ? (r_alloc_ptr - w_passe_nxt) : '0;

  stq_range_mask u_passe_mask (
    .i_start (r_passe_ptr[IDX_W-1:0]),
    .i_count (w_passe_cnt),
    .o_mask  (w_passe_mask)
  );

  stq_range_mask u_flush_mask (
    .i_start (w_passe_nxt[IDX_W-1:0]),
    .i_count (w_flush_cnt),
    .o_mask  (w_flush_mask)
  );

  assign bus.passe_en = w_passe_mask;

  // ---------------------------------------------------------------------------
  // Drain: the oldest retired entry is offered to the cache. drain_id comes
  // straight from free_ptr, which only moves on an accepted drain, so it is
  // stable while the cache back-pressures.
  // ---------------------------------------------------------------------------
  assign w_drain_vld  = ~rst & (r_passe_ptr != r_free_ptr);
  assign w_drain_fire = w_drain_vld & bus.drain_ready;
  assign w_drain_id   = r_free_ptr[IDX_W-1:0];

  assign bus.drain_valid = w_drain_vld;
  assign bus.drain_id    = w_drain_id;
  // Drained entries are retired and flushed ones are not, so the two
  // contributions never overlap.
  assign bus.free_en     = w_flush_mask | (w_drain_fire ? onehot(w_drain_id) : '0);

  assign bus.used_cnt = w_used;
  assign bus.full     = (w_used == stq_ptr_t'(BUF_COUNT));
  assign bus.empty    = (w_used == '0);

  // ---------------------------------------------------------------------------
  // Pointer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc_ptr <= '0;
      r_passe_ptr <= '0;
      r_free_ptr  <= '0;
    end else begin
      r_passe_ptr <= w_passe_nxt;
      if (w_drain_fire) begin
        r_free_ptr <= r_free_ptr + stq_ptr_t'(1);
      end
      // A flush rewinds allocation to the first unretired entry; no grant
      // can coincide with it.
      if (bus.excpt) begin
        r_alloc_ptr <= w_passe_nxt;
      end else if (w_gnt) begin
        r_alloc_ptr <= r_alloc_ptr + stq_ptr_t'(bus.alloc_req);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Usage checks
  // ---------------------------------------------------------------------------
  a_retire_within_alloc: assert property (@(posedge clk) disable iff (rst)
    w_retire_cnt <= (r_alloc_ptr - r_passe_ptr));

  a_alloc_req_legal: assert property (@(posedge clk) disable iff (rst)
    bus.alloc_req != 2'd3);

  a_ptr_order: assert property (@(posedge clk) disable iff (rst)
    (r_passe_ptr - r_free_ptr) <= (r_alloc_ptr - r_free_ptr));

  a_used_bound: assert property (@(posedge clk) disable iff (rst)
    w_used <= stq_ptr_t'(BUF_COUNT));

endmodule
